dcache_ctrl: RTL and testbench

Direct-mapped, write-through data-cache controller for the MEM stage. Serves loads and stores from the pipeline, supplies the four line bytes and byte selector that the MEM/WB pipeline register latches, and drives `freeze` to stall the whole pipeline during memory round trips. On the other side it talks to main memory through a request/ready handshake.

---
 rtl/dcache_ctrl_pkg.sv | 21 ++
 rtl/dcache_ctrl_if.sv | 36 +++
 rtl/dcache_ctrl_array.sv | 64 ++++++
 rtl/dcache_ctrl.sv | 142 ++++++++++++++
 tb/tb_dcache_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/dcache_ctrl_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
package mips_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } dcache_state_t;

  localparam int LINE_BYTES = 4;

  // Byte lanes are numbered big-endian: lane 0 is the most significant byte.
  function automatic logic [0:LINE_BYTES-1] be_from_offset(input logic [1:0] off);
    logic [0:LINE_BYTES-1] be;
    be      = '0;
    be[off] = 1'b1;
    return be;
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side signals of the data-cache controller.
interface dcache_ctrl_if
  import mips_cache_pkg::*;
#(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0]             cpu_addr;
  logic                          cpu_rd;
  logic                          cpu_wr;
  logic                          cpu_is_byte;
  logic [31:0]                   cpu_wdata;
  logic [0:LINE_BYTES-1][7:0]    cache_data_out;
  logic [1:0]                    mem_block;
  logic                          freeze;
  logic [ADDR_W-1:0]             mem_addr;
  logic                          mem_rd_req;
  logic                          mem_wr_req;
  logic [31:0]                   mem_wdata;
  logic [0:LINE_BYTES-1]         mem_be;
  logic [31:0]                   mem_rdata;
  logic                          mem_ready;

  modport slave (
    input  cpu_addr, cpu_rd, cpu_wr, cpu_is_byte, cpu_wdata, mem_rdata, mem_ready,
    output cache_data_out, mem_block, freeze, mem_addr, mem_rd_req, mem_wr_req,
           mem_wdata, mem_be
  );

  modport master (
    output cpu_addr, cpu_rd, cpu_wr, cpu_is_byte, cpu_wdata, mem_rdata, mem_ready,
    input  cache_data_out, mem_block, freeze, mem_addr, mem_rd_req, mem_wr_req,
           mem_wdata, mem_be
  );

endinterface

// File: rtl/dcache_ctrl_array.sv
// Valid/tag/data storage: combinational reads, byte-lane writes, sync valid clear.
module dcache_array
  import mips_cache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 26
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic [IDX_W-1:0]           i_rd_idx,
  output logic                       o_rd_valid,
  output logic [TAG_W-1:0]           o_rd_tag,
  output logic [0:LINE_BYTES-1][7:0] o_rd_data,
  input  logic [IDX_W-1:0]           i_chk_idx,
  output logic                       o_chk_valid,
  output logic [TAG_W-1:0]           o_chk_tag,
  input  logic                       i_wr_en,
  input  logic                       i_wr_fill,
  input  logic [IDX_W-1:0]           i_wr_idx,
  input  logic [TAG_W-1:0]           i_wr_tag,
  input  logic [0:LINE_BYTES-1]      i_wr_be,
  input  logic [0:LINE_BYTES-1][7:0] i_wr_data
);

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [LINES];

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_valid <= '0;
    end else if (i_wr_en && i_wr_fill) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en && i_wr_fill) begin
      r_tag[i_wr_idx] <= i_wr_tag;
    end
  end

  // One storage array per byte lane so a byte store touches only its lane.
  genvar gi;
  generate
    for (gi = 0; gi < LINE_BYTES; gi++) begin : g_lane
      logic [7:0] r_lane [LINES];

      always_ff @(posedge clk) begin
        if (i_wr_en && i_wr_be[gi]) begin
          r_lane[i_wr_idx] <= i_wr_data[gi];
        end
      end

      assign o_rd_data[gi] = r_lane[i_rd_idx];
    end
  endgenerate

  assign o_rd_valid  = r_valid[i_rd_idx];
  assign o_rd_tag    = r_tag[i_rd_idx];
  assign o_chk_valid = r_valid[i_chk_idx];
  assign o_chk_tag   = r_tag[i_chk_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through D-cache controller: hit/miss, line fill, store
// write-through with hit merge, and pipeline freeze generation.
module dcache_ctrl
  import mips_cache_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int ADDR_W = 32
) (
  input logic          clk,
  input logic          rst_b,
  dcache_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  dcache_state_t         r_state;
  logic [ADDR_W-3:0]     r_waddr;
  logic [31:0]           r_wdata;
  logic [0:LINE_BYTES-1] r_be;
  logic                  r_rd_req;
  logic                  r_wr_req;

  logic [IDX_W-1:0]           w_idx;
  logic [TAG_W-1:0]           w_tag;
  logic                       w_rd_valid;
  logic [TAG_W-1:0]           w_rd_tag;
  logic [0:LINE_BYTES-1][7:0] w_rd_data;
  logic                       w_hit;
  logic [IDX_W-1:0]           w_l_idx;
  logic [TAG_W-1:0]           w_l_tag;
  logic                       w_chk_valid;
  logic [TAG_W-1:0]           w_chk_tag;
  logic                       w_chk_hit;
  logic                       w_fill_we;
  logic                       w_store_we;
  logic [0:LINE_BYTES-1]      w_wr_be;
  logic [31:0]                w_wr_data;
  logic                       w_freeze;

  assign w_idx   = bus.cpu_addr[IDX_W+1:2];
  assign w_tag   = bus.cpu_addr[ADDR_W-1:IDX_W+2];
  assign w_hit   = w_rd_valid && (w_rd_tag == w_tag);
  assign w_l_idx = r_waddr[IDX_W-1:0];
  assign w_l_tag = r_waddr[ADDR_W-3:IDX_W];

  // Store merge is decided against the latched address, not the live one.
  assign w_chk_hit  = w_chk_valid && (w_chk_tag == w_l_tag);
  assign w_fill_we  = (r_state == FILL) && bus.mem_ready;
  assign w_store_we = (r_state == WRITE) && bus.mem_ready && w_chk_hit;
  assign w_wr_be    = w_fill_we ? {LINE_BYTES{1'b1}} : r_be;
  assign w_wr_data  = w_fill_we ? bus.mem_rdata : r_wdata;

  dcache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk         (clk),
    .rst_b       (rst_b),
    .i_rd_idx    (w_idx),
    .o_rd_valid  (w_rd_valid),
    .o_rd_tag    (w_rd_tag),
    .o_rd_data   (w_rd_data),
    .i_chk_idx   (w_l_idx),
    .o_chk_valid (w_chk_valid),
    .o_chk_tag   (w_chk_tag),
    .i_wr_en     (w_fill_we || w_store_we),
    .i_wr_fill   (w_fill_we),
    .i_wr_idx    (w_l_idx),
    .i_wr_tag    (w_l_tag),
    .i_wr_be     (w_wr_be),
    .i_wr_data   (w_wr_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state  <= IDLE;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_rd_req <= 1'b0;
      r_wr_req <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cpu_wr) begin
            r_state  <= WRITE;
            r_waddr  <= bus.cpu_addr[ADDR_W-1:2];
            r_wdata  <= bus.cpu_is_byte ? {4{bus.cpu_wdata[7:0]}} : bus.cpu_wdata;
            r_be     <= bus.cpu_is_byte ? be_from_offset(bus.cpu_addr[1:0])
                                        : {LINE_BYTES{1'b1}};
            r_wr_req <= 1'b1;
          end else if (bus.cpu_rd && !w_hit) begin
            r_state  <= FILL;
            r_waddr  <= bus.cpu_addr[ADDR_W-1:2];
            r_rd_req <= 1'b1;
          end
        end
        FILL: begin
          if (bus.mem_ready) begin
            r_state  <= IDLE;
            r_rd_req <= 1'b0;
          end
        end
        WRITE: begin
          if (bus.mem_ready) begin
            r_state  <= DONE;
            r_wr_req <= 1'b0;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_freeze = 1'b0;
    case (r_state)
      IDLE:    w_freeze = bus.cpu_wr || (bus.cpu_rd && !w_hit);
      FILL:    w_freeze = 1'b1;
      WRITE:   w_freeze = 1'b1;
      DONE:    w_freeze = 1'b0;
      default: w_freeze = 1'b0;
    endcase
  end

  assign bus.freeze         = w_freeze;
  assign bus.cache_data_out = w_rd_data;
  assign bus.mem_block      = bus.cpu_addr[1:0];
  assign bus.mem_addr       = {r_waddr, 2'b00};
  assign bus.mem_rd_req     = r_rd_req;
  assign bus.mem_wr_req     = r_wr_req;
  assign bus.mem_wdata      = r_wdata;
  assign bus.mem_be         = r_be;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed, table-driven bench for dcache_ctrl plus hand-written reset/latency sequences.
module tb_dcache_ctrl;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;

  always #5 clk = ~clk;

  dcache_ctrl_if #(.ADDR_W(32)) bus ();

  dcache_ctrl #(
    .LINES  (16),
    .ADDR_W (32)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.slave)
  );

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic        byt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdy;
    logic [31:0] rdata;
    logic        f;
    logic        rq;
    logic        wq;
    logic        cd;
    logic [31:0] data;
    logic        ca;
    logic [31:0] maddr;
    logic        cw;
    logic [3:0]  be;
    logic [31:0] mwd;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic byt,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic rdy, input logic [31:0] rdata);
    bus.cpu_rd      = rd;
    bus.cpu_wr      = wr;
    bus.cpu_is_byte = byt;
    bus.cpu_addr    = addr;
    bus.cpu_wdata   = wdata;
    bus.mem_ready   = rdy;
    bus.mem_rdata   = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string name, input logic rd, input logic wr, input logic byt,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic rdy, input logic [31:0] rdata,
                     input logic f, input logic rq, input logic wq,
                     input logic cd, input logic [31:0] data,
                     input logic ca, input logic [31:0] maddr,
                     input logic cw, input logic [3:0] be, input logic [31:0] mwd);
    vec_t v;
    v.name = name;  v.rd = rd;   v.wr = wr;    v.byt = byt;  v.addr = addr;
    v.wdata = wdata; v.rdy = rdy; v.rdata = rdata;
    v.f = f;  v.rq = rq;  v.wq = wq;  v.cd = cd;  v.data = data;
    v.ca = ca;  v.maddr = maddr;  v.cw = cw;  v.be = be;  v.mwd = mwd;
    vq.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;
    int lat;

    //   name             rd wr by addr      wdata         rdy rdata          f  rq wq cd data           ca maddr    cw be       mwd
    add("miss40_c0",      1, 0, 0, 'h40, 'h0,          0, 'h0,           1, 0, 0, 0, 'h0,          0, 'h0,  0, 4'b0000, 'h0);
    add("miss40_c1",      1, 0, 0, 'h40, 'h0,          0, 'h0,           1, 1, 0, 0, 'h0,          1, 'h40, 0, 4'b0000, 'h0);
    add("miss40_c2",      1, 0, 0, 'h40, 'h0,          0, 'h0,           1, 1, 0, 0, 'h0,          1, 'h40, 0, 4'b0000, 'h0);
    add("miss40_c3",      1, 0, 0, 'h40, 'h0,          1, 'h11223344,    1, 1, 0, 0, 'h0,          1, 'h40, 0, 4'b0000, 'h0);
    add("hit40",          1, 0, 0, 'h40, 'h0,          0, 'h0,           0, 0, 0, 1, 'h11223344,   0, 'h0,  0, 4'b0000, 'h0);
    add("lb43",           1, 0, 1, 'h43, 'h0,          0, 'h0,           0, 0, 0, 1, 'h11223344,   0, 'h0,  0, 4'b0000, 'h0);
    add("sb41_c0",        0, 1, 1, 'h41, 'hAB,         0, 'h0,           1, 0, 0, 0, 'h0,          0, 'h0,  0, 4'b0000, 'h0);
    add("sb41_c1",        0, 1, 1, 'h41, 'hAB,         0, 'h0,           1, 0, 1, 0, 'h0,          1, 'h40, 1, 4'b0100, 'hABABABAB);
    add("sb41_c2",        0, 1, 1, 'h41, 'hAB,         1, 'h0,           1, 0, 1, 0, 'h0,          1, 'h40, 1, 4'b0100, 'hABABABAB);
    add("sb41_done",      0, 1, 1, 'h41, 'hAB,         0, 'h0,           0, 0, 0, 0, 'h0,          0, 'h0,  0, 4'b0000, 'h0);
    add("rd40_merged",    1, 0, 0, 'h40, 'h0,          0, 'h0,           0, 0, 0, 1, 'h11AB3344,   0, 'h0,  0, 4'b0000, 'h0);
    add("ready_idle",     1, 0, 0, 'h40, 'h0,          1, 'h55555555,    0, 0, 0, 1, 'h11AB3344,   0, 'h0,  0, 4'b0000, 'h0);
    add("idle_after",     0, 0, 0, 'h44, 'h0,          0, 'h0,           0, 0, 0, 0, 'h0,          0, 'h0,  0, 4'b0000, 'h0);
    add("sw80_c0",        0, 1, 0, 'h80, 'hDEADBEEF,   0, 'h0,           1, 0, 0, 1, 'h11AB3344,   0, 'h0,  0, 4'b0000, 'h0);
    add("sw80_c1",        0, 1, 0, 'h80, 'hDEADBEEF,   0, 'h0,           1, 0, 1, 0, 'h0,          1, 'h80, 1, 4'b1111, 'hDEADBEEF);
    add("sw80_c2",        0, 1, 0, 'h80, 'hDEADBEEF,   1, 'h0,           1, 0, 1, 0, 'h0,          1, 'h80, 1, 4'b1111, 'hDEADBEEF);
    add("sw80_done",      0, 1, 0, 'h80, 'hDEADBEEF,   1, 'h0,           0, 0, 0, 0, 'h0,          0, 'h0,  0, 4'b0000, 'h0);
    add("rd80_miss",      1, 0, 0, 'h80, 'h0,          0, 'h0,           1, 0, 0, 1, 'h11AB3344,   0, 'h0,  0, 4'b0000, 'h0);
    add("rd80_fill",      1, 0, 0, 'h80, 'h0,          1, 'hCAFEF00D,    1, 1, 0, 0, 'h0,          1, 'h80, 0, 4'b0000, 'h0);
    add("rd80_hit",       1, 0, 0, 'h80, 'h0,          0, 'h0,           0, 0, 0, 1, 'hCAFEF00D,   0, 'h0,  0, 4'b0000, 'h0);
    add("rd40_conflict",  1, 0, 0, 'h40, 'h0,          0, 'h0,           1, 0, 0, 1, 'hCAFEF00D,   0, 'h0,  0, 4'b0000, 'h0);
    add("rd40_refill",    1, 0, 0, 'h40, 'h0,          1, 'h11AB3344,    1, 1, 0, 0, 'h0,          1, 'h40, 0, 4'b0000, 'h0);
    add("rd40_hit",       0, 0, 0, 'h40, 'h0,          0, 'h0,           0, 0, 0, 1, 'h11AB3344,   0, 'h0,  0, 4'b0000, 'h0);

    // Reset: outputs idle, and a read during reset sees an empty cache.
    drive(0, 0, 0, 'h0, 'h0, 0, 'h0);
    rst_b = 1'b0;
    tick();
    tick();
    #1;
    chk("reset_rd_req", {31'b0, bus.mem_rd_req}, 32'd0);
    chk("reset_wr_req", {31'b0, bus.mem_wr_req}, 32'd0);
    chk("reset_freeze", {31'b0, bus.freeze}, 32'd0);
    drive(1, 0, 0, 'h40, 'h0, 0, 'h0);
    #1;
    chk("reset_freeze_rd", {31'b0, bus.freeze}, 32'd1);
    tick();
    chk("reset_hold_rd_req", {31'b0, bus.mem_rd_req}, 32'd0);
    $display("txn reset done");
    drive(0, 0, 0, 'h0, 'h0, 0, 'h0);
    rst_b = 1'b1;
    tick();

    foreach (vq[i]) begin
      drive(vq[i].rd, vq[i].wr, vq[i].byt, vq[i].addr, vq[i].wdata, vq[i].rdy, vq[i].rdata);
      #1;
      chk({vq[i].name, "_freeze"}, {31'b0, bus.freeze}, {31'b0, vq[i].f});
      chk({vq[i].name, "_rd_req"}, {31'b0, bus.mem_rd_req}, {31'b0, vq[i].rq});
      chk({vq[i].name, "_wr_req"}, {31'b0, bus.mem_wr_req}, {31'b0, vq[i].wq});
      chk({vq[i].name, "_block"}, {30'b0, bus.mem_block}, {30'b0, vq[i].addr[1:0]});
      if (vq[i].cd) chk({vq[i].name, "_data"}, bus.cache_data_out, vq[i].data);
      if (vq[i].ca) chk({vq[i].name, "_mem_addr"}, bus.mem_addr, vq[i].maddr);
      if (vq[i].cw) begin
        chk({vq[i].name, "_mem_be"}, {28'b0, bus.mem_be}, {28'b0, vq[i].be});
        chk({vq[i].name, "_mem_wdata"}, bus.mem_wdata, vq[i].mwd);
      end
      $display("txn %0d %s freeze=%0b rd_req=%0b wr_req=%0b data=%08h",
               i, vq[i].name, bus.freeze, bus.mem_rd_req, bus.mem_wr_req, bus.cache_data_out);
      tick();
    end

    // Reset in the middle of a fill abandons it and clears the valid bits.
    drive(1, 0, 0, 'hC0, 'h0, 0, 'h0);
    #1;
    chk("rstfill_freeze", {31'b0, bus.freeze}, 32'd1);
    tick();
    chk("rstfill_rd_req", {31'b0, bus.mem_rd_req}, 32'd1);
    rst_b = 1'b0;
    drive(0, 0, 0, 'h0, 'h0, 0, 'h0);
    tick();
    rst_b = 1'b1;
    #1;
    chk("rstfill_after_rd_req", {31'b0, bus.mem_rd_req}, 32'd0);
    chk("rstfill_after_wr_req", {31'b0, bus.mem_wr_req}, 32'd0);
    chk("rstfill_after_freeze", {31'b0, bus.freeze}, 32'd0);
    drive(1, 0, 0, 'h40, 'h0, 0, 'h0);
    #1;
    chk("rstfill_rd40_miss", {31'b0, bus.freeze}, 32'd1);
    $display("txn reset_in_fill freeze=%0b rd_req=%0b", bus.freeze, bus.mem_rd_req);
    tick();

    // Refill 0x40 with a randomised memory latency, bounded wait on the request.
    waited = 0;
    while (!bus.mem_rd_req && waited < 8) begin
      tick();
      waited++;
    end
    chk("lat_rd_req_seen", {31'b0, bus.mem_rd_req}, 32'd1);
    lat = $urandom_range(0, 2);
    repeat (lat) begin
      #1;
      chk("lat_wait_freeze", {31'b0, bus.freeze}, 32'd1);
      tick();
    end
    drive(1, 0, 0, 'h40, 'h0, 1, 'h0BADF00D);
    #1;
    chk("lat_ready_freeze", {31'b0, bus.freeze}, 32'd1);
    tick();
    drive(1, 0, 0, 'h40, 'h0, 0, 'h0);
    #1;
    chk("lat_hit_freeze", {31'b0, bus.freeze}, 32'd0);
    chk("lat_hit_rd_req", {31'b0, bus.mem_rd_req}, 32'd0);
    chk("lat_hit_data", bus.cache_data_out, 32'h0BADF00D);
    $display("txn latency_fill lat=%0d data=%08h", lat + 1, bus.cache_data_out);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
